// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-side pins of the unified memory port arbiter.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory; one access at a time.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              fetch;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } acc_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_t             acc_q, acc_d;
  logic             en_q, we_q;
  logic [31:0]      if_rdata_q, d_rdata_q;
  logic             grant, capture, starve_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_W'(MEM_LAT);
          // data serves the older instruction, so fetch only wins on a free port or a starve hit
          if (bus.if_req && (!bus.d_req || starve_hit))
            acc_d = '{fetch: 1'b1, we: 1'b0, be: 4'hF, addr: bus.if_addr, wdata: 32'h0};
          else
            acc_d = '{fetch: 1'b0, we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      en_q    <= grant;
      we_q    <= grant & acc_d.we;
      if (capture && !acc_q.we) begin
        if (acc_q.fetch) if_rdata_q <= bus.mem_rdata;
        else             d_rdata_q  <= bus.mem_rdata;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));

  // counts data grants that left a pending fetch waiting; saturates at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant) begin
      if (acc_d.fetch || !bus.if_req) starve_q <= '0;
      else if (!starve_hit)           starve_q <= starve_q + SW'(1);
    end
  end
`else
  // strict data priority
  assign starve_hit = (STARVE_MAX < 0);
`endif

  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = acc_q.be;
  assign bus.mem_addr  = acc_q.addr;
  assign bus.mem_wdata = acc_q.wdata;
  assign bus.if_ack    = (state_q == DONE) &&  acc_q.fetch;
  assign bus.d_ack     = (state_q == DONE) && !acc_q.fetch;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal checks plus randomized traffic against a timing model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32, L = 1, L2 = 3, SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus();
  mem_port_arbiter_if #(.ADDR_W(AW)) bus2();

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(L2), .STARVE_MAX(SMAX)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2));

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory: sparse word store with a hashed default, read data MEM_LAT cycles after mem_en
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rpipe [L];
  logic [31:0] mw;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      rpipe[0] <= mrd(bus.mem_addr);
      if (bus.mem_we) begin
        mw = mrd(bus.mem_addr);
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mw[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        mem[bus.mem_addr] = mw;
      end
    end else begin
      rpipe[0] <= $urandom;
    end
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata  = rpipe[L-1];
  assign bus2.mem_rdata = 32'h0000CAFE;

  // transaction-timing model: grant at cycle g -> mem_en g+1, ack g+2+L, next decision g+3+L
  int          cyc = 0, g = 0, st = 0;
  bit          act = 1'b0, own_f, we_l, en_e, bsy_e, ack_e;
  logic [3:0]  be_l;
  logic [31:0] addr_l, wd_l, rd_l, exp_if = '0, exp_d = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_if_ack", bus.if_ack, 0);   chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_busy", bus.busy, 0);       chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);   chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rdata", bus.if_rdata, 0); chk("rst_d_rdata", bus.d_rdata, 0);
      act = 1'b0; st = 0; exp_if = '0; exp_d = '0;
    end else begin
      en_e  = act && (cyc == g + 1);
      bsy_e = act && (cyc >= g + 1) && (cyc <= g + 2 + L);
      ack_e = act && (cyc == g + 2 + L);
      if (ack_e && !we_l) begin
        if (own_f) exp_if = rd_l;
        else       exp_d  = rd_l;
      end
      chk("m_mem_en", bus.mem_en, en_e);
      chk("m_mem_we", bus.mem_we, en_e && we_l);
      chk("m_busy", bus.busy, bsy_e);
      chk("m_if_ack", bus.if_ack, ack_e && own_f);
      chk("m_d_ack", bus.d_ack, ack_e && !own_f);
      chk("m_if_rdata", bus.if_rdata, exp_if);
      chk("m_d_rdata", bus.d_rdata, exp_d);
      if (en_e) begin
        chk("m_mem_addr", bus.mem_addr, addr_l);
        chk("m_mem_be", bus.mem_be, be_l);
        if (we_l) chk("m_mem_wdata", bus.mem_wdata, wd_l);
      end
      if ((!act || cyc >= g + 3 + L) && (bus.if_req || bus.d_req)) begin
        own_f = bus.if_req && (!bus.d_req || (GUARD && st == SMAX));
        if (own_f || !bus.if_req) st = 0;
        else if (st < SMAX)       st = st + 1;
        addr_l = own_f ? bus.if_addr : bus.d_addr;
        we_l   = own_f ? 1'b0 : bus.d_we;
        be_l   = own_f ? 4'hF : bus.d_be;
        wd_l   = bus.d_wdata;
        rd_l   = mrd(addr_l);
        act    = 1'b1;
        g      = cyc;
      end
    end
  end

  task automatic nx(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] a, output bit ok);
    bus.if_req = 1'b1; bus.if_addr = a; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.if_ack) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = $urandom;
  endtask

  task automatic do_data(input bit we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, output bit ok);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = a; bus.d_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.d_ack) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = $urandom; bus.d_be = $urandom;
    bus.d_addr = $urandom; bus.d_wdata = $urandom;
  endtask

  bit          okf, okd;
  int          n, acks2, busy2;
  logic [7:0]  pat;

  initial begin
    mem[32'h10] = 32'h00500093; mem[32'h20] = 32'h11112222; mem[32'h30] = 32'h33334444;
    mem[32'h40] = 32'hAAAAAAAA; mem[32'h80] = 32'h12345678;
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h30; bus.d_wdata = '0;
    bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_be = 4'hF; bus2.d_addr = '0; bus2.d_wdata = '0;

    // reset held with both requests high
    nx(2);
    chk("reset_busy", bus.busy, 0);
    chk("reset_mem_en", bus.mem_en, 0);
    @(posedge clk); #1; rst = 1'b1; rst2 = 1'b1;

    // collision: data first, fetch after
    nx(1); chk("col_mem_en", bus.mem_en, 1); chk("col_addr_d", bus.mem_addr, 32'h30);
    nx(2); chk("col_d_ack", bus.d_ack, 1); chk("col_if_ack_c3", bus.if_ack, 0);
    chk("col_d_rdata", bus.d_rdata, 32'h33334444);
    @(posedge clk); #1; bus.d_req = 1'b0;
    nx(1); chk("col_f_mem_en", bus.mem_en, 1); chk("col_addr_f", bus.mem_addr, 32'h20);
    nx(2); chk("col_if_ack", bus.if_ack, 1); chk("col_if_rdata", bus.if_rdata, 32'h11112222);
    @(posedge clk); #1; bus.if_req = 1'b0;

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    nx(1); chk("f_mem_en", bus.mem_en, 1); chk("f_mem_addr", bus.mem_addr, 32'h10);
    chk("f_mem_we", bus.mem_we, 0);
    nx(2); chk("f_if_ack", bus.if_ack, 1); chk("f_if_rdata", bus.if_rdata, 32'h00500093);
    @(posedge clk); #1; bus.if_req = 1'b0;
    nx(0); chk("f_busy_c4", bus.busy, 0);

    // load then store; the store leaves d_rdata alone
    @(posedge clk); #1;
    do_data(1'b0, 4'hF, 32'h80, 32'h0, okd);
    chk("ld_ack_seen", okd, 1); chk("ld_rdata", bus.d_rdata, 32'h12345678);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
    nx(1); chk("st_mem_en", bus.mem_en, 1); chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_be", bus.mem_be, 4'b0011); chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    nx(1); chk("st_single_en", bus.mem_en, 0);
    nx(1); chk("st_d_ack", bus.d_ack, 1); chk("st_d_rdata", bus.d_rdata, 32'h12345678);
    @(posedge clk); #1; bus.d_req = 1'b0; bus.d_we = 1'b0;
    chk("st_mem_word", mem[32'h40], 32'hAAAABEEF);

    // request dropped after one cycle still completes
    bus.d_req = 1'b1; bus.d_addr = 32'h30; bus.d_be = 4'hF;
    @(posedge clk); #1; bus.d_req = 1'b0;
    nx(0); chk("drop_mem_en", bus.mem_en, 1);
    nx(2); chk("drop_d_ack", bus.d_ack, 1); chk("drop_rdata", bus.d_rdata, 32'h33334444);
    nx(1); chk("drop_idle", bus.busy, 0);

    // both requests held high: grant order
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h88; bus.d_req = 1'b1; bus.d_addr = 32'h84;
    pat = '0; n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(negedge clk);
      if (bus.d_ack) n++;
      else if (bus.if_ack) begin pat[n[2:0]] = 1'b1; n++; end
    end
    chk("starve_acks", n, 8);
    chk("starve_pattern", pat, GUARD ? 8'h10 : 8'h00);
    @(posedge clk); #1; bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // randomized traffic, model checks every cycle
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          do_fetch({24'h0, 6'($urandom_range(0, 63)), 2'b00}, okf);
          chk("rnd_fetch_done", okf, 1);
        end
      end
      begin
        for (int t = 0; t < 150; t++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_data(1'($urandom), 4'($urandom), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                  $urandom, okd);
          chk("rnd_data_done", okd, 1);
        end
      end
    join

    // MEM_LAT=3 instance: latency, then reset in the second ACCESS cycle
    @(posedge clk); #1; bus2.d_req = 1'b1; bus2.d_addr = 32'h44;
    nx(1); chk("l3_mem_en", bus2.mem_en, 1);
    nx(3); chk("l3_ack_c4", bus2.d_ack, 0);
    nx(1); chk("l3_ack_c5", bus2.d_ack, 1); chk("l3_rdata", bus2.d_rdata, 32'h0000CAFE);
    @(posedge clk); #1; bus2.d_req = 1'b0;
    @(posedge clk); #1; bus2.d_req = 1'b1;
    nx(1); chk("l3b_mem_en", bus2.mem_en, 1); chk("l3b_busy", bus2.busy, 1);
    @(posedge clk); #2; bus2.d_req = 1'b0; rst2 = 1'b0;
    #1; chk("abort_busy", bus2.busy, 0); chk("abort_mem_en", bus2.mem_en, 0);
    chk("abort_d_ack", bus2.d_ack, 0); chk("abort_if_ack", bus2.if_ack, 0);
    chk("abort_rdata", bus2.d_rdata, 0);
    @(posedge clk); #1; rst2 = 1'b1;
    acks2 = 0; busy2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus2.d_ack || bus2.if_ack) acks2++;
      if (bus2.busy) busy2++;
    end
    chk("abort_no_ack", acks2, 0); chk("abort_no_busy", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
